// File: rtl/hgcal_pkg.sv
// hgcal_pkg: shared definitions for the HGCAL autoencoder input stages.
//   HGCAL_Q_BITS     - quantised code width per feature
//   HGCAL_IN_WIDTH   - default raw sample width
//   state_e          - packer frame-assembly state
//   clog2()          - counter width helper (never returns less than 1)
package hgcal_pkg;

  localparam int HGCAL_Q_BITS   = 2;
  localparam int HGCAL_IN_WIDTH = 8;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/hgcal_quantiser.sv
// hgcal_quantiser: combinational shift-and-saturate of one unsigned sample.
//   data_i [IN_WIDTH] - raw unsigned sample
//   q_o    [Q_BITS]   - (data_i >> SHIFT) clamped to 2^Q_BITS-1
module hgcal_quantiser
  import hgcal_pkg::*;
#(
  parameter int IN_WIDTH = HGCAL_IN_WIDTH,
  parameter int Q_BITS   = HGCAL_Q_BITS,
  parameter int SHIFT    = 2
) (
  input  logic [IN_WIDTH-1:0] data_i,
  output logic [Q_BITS-1:0]   q_o
);

  localparam logic [IN_WIDTH-1:0] QMAX = IN_WIDTH'((1 << Q_BITS) - 1);

  logic [IN_WIDTH-1:0] shifted;

  always_comb begin
    shifted = data_i >> SHIFT;
    if (shifted > QMAX) q_o = '1;
    else                q_o = shifted[Q_BITS-1:0];
  end

endmodule

// File: rtl/hgcal_input_packer.sv
// hgcal_input_packer: quantises a stream of raw samples (one feature per beat)
// and packs NUM_FEATURES codes into a registered output slot.
//   clk, rst      - clock, synchronous active-high reset
//   s_valid/s_ready/s_data/s_last - raw sample stream
//   m_valid/m_ready/m_data        - packed frame, feature i at [i*Q_BITS +: Q_BITS]
//   err_short     - pulse: s_last arrived before NUM_FEATURES beats
//   err_long      - pulse: NUM_FEATURES-th beat arrived without s_last
//   frame_count   - frames handed off on the m side (wraps)
module hgcal_input_packer
  import hgcal_pkg::*;
#(
  parameter int NUM_FEATURES = 48,
  parameter int IN_WIDTH     = HGCAL_IN_WIDTH,
  parameter int Q_BITS       = HGCAL_Q_BITS,
  parameter int SHIFT        = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [IN_WIDTH-1:0]            s_data,
  input  logic                           s_last,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [NUM_FEATURES*Q_BITS-1:0] m_data,
  output logic                           err_short,
  output logic                           err_long,
  output logic [15:0]                    frame_count
);

  localparam int                FW       = NUM_FEATURES * Q_BITS;
  localparam int                CW       = clog2(NUM_FEATURES);
  localparam logic [CW-1:0]     LAST_IDX = CW'(NUM_FEATURES - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic            disc_q, disc_d;
  logic            m_valid_q, m_valid_d;
  logic [FW-1:0]   m_data_q, m_data_d;
  logic            err_short_q, err_short_d;
  logic            err_long_q, err_long_d;
  logic [15:0]     fcnt_q, fcnt_d;

  logic [Q_BITS-1:0] q;
  logic [FW-1:0]     frame;
  logic              beat, slot_free, at_last_idx, is_long;

  hgcal_quantiser #(
    .IN_WIDTH (IN_WIDTH),
    .Q_BITS   (Q_BITS),
    .SHIFT    (SHIFT)
  ) u_quant (
    .data_i (s_data),
    .q_o    (q)
  );

  assign s_ready     = !rst && (state_q != WAIT);
  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign err_short   = err_short_q;
  assign err_long    = err_long_q;
  assign frame_count = fcnt_q;

  // Slots above the current index are already zero because the fill buffer
  // is cleared at every handoff, so an early s_last needs no extra masking.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fill_d      = fill_q;
    disc_d      = disc_q;
    m_valid_d   = m_valid_q && !m_ready;
    m_data_d    = m_data_q;
    err_short_d = 1'b0;
    err_long_d  = 1'b0;
    fcnt_d      = (m_valid_q && m_ready) ? fcnt_q + 16'd1 : fcnt_q;

    beat        = s_valid && s_ready;
    slot_free   = !m_valid_q || m_ready;
    at_last_idx = (cnt_q == LAST_IDX);
    is_long     = at_last_idx && !s_last;
    frame       = fill_q;
    frame[cnt_q*Q_BITS +: Q_BITS] = q;

    unique case (state_q)
      FILL: begin
        if (beat) begin
          if (at_last_idx || s_last) begin
            err_short_d = s_last && !at_last_idx;
            err_long_d  = is_long;
            cnt_d       = '0;
            if (slot_free) begin
              m_data_d  = frame;
              m_valid_d = 1'b1;
              fill_d    = '0;
              state_d   = is_long ? DISCARD : FILL;
            end else begin
              fill_d  = frame;
              disc_d  = is_long;
              state_d = WAIT;
            end
          end else begin
            fill_d = frame;
            cnt_d  = cnt_q + CW'(1);
          end
        end
      end
      WAIT: begin
        if (m_ready) begin
          m_data_d  = fill_q;
          m_valid_d = 1'b1;
          fill_d    = '0;
          disc_d    = 1'b0;
          state_d   = disc_q ? DISCARD : FILL;
        end
      end
      DISCARD: begin
        if (beat && s_last) begin
          state_d = FILL;
          cnt_d   = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      fill_q      <= '0;
      disc_q      <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      fcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fill_q      <= fill_d;
      disc_q      <= disc_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      fcnt_q      <= fcnt_d;
    end
  end

endmodule

// File: doc/hgcal_input_packer.md
Name: hgcal_input_packer

Overview:
Upstream front end of the quantised HGCAL autoencoder. It accepts raw unsigned sensor samples one feature per beat on a valid/ready stream and quantises each to Q_BITS by shift-and-saturate. It packs one frame of NUM_FEATURES codes into the flat vector that drives the layer-0 LUT neurons, then holds it in a registered output slot with its own valid/ready handshake. Frame-length errors are detected and flagged.

Parameters:
NUM_FEATURES, 48, features per frame (beats per well-formed frame)
IN_WIDTH, 8, raw sample width, unsigned
Q_BITS, 2, quantised code width per feature
SHIFT, 2, right-shift applied before saturation

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
s_valid  in  1  input sample valid
s_ready  out  1  packer can accept a sample
s_data  in  IN_WIDTH  raw sample
s_last  in  1  final sample of frame
m_valid  out  1  packed frame valid
m_ready  in  1  layer-0 consumer accepts frame
m_data  out  NUM_FEATURES*Q_BITS  packed codes; feature i at bits [i*Q_BITS +: Q_BITS]
err_short  out  1  one-cycle pulse: s_last before NUM_FEATURES beats
err_long  out  1  one-cycle pulse: NUM_FEATURES-th beat without s_last
frame_count  out  16  frames delivered on m side, wraps at 2^16

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. While rst is high, every register is cleared on the clock edge.
- Reset values: s_ready=0 during rst and 1 the cycle after. m_valid=0, m_data=0, err_short=0, err_long=0, frame_count=0. State is FILL, beat counter is 0, fill buffer is 0.
- Quantisation (combinational, per beat): q = s_data >> SHIFT. If q > 2^Q_BITS-1, q = 2^Q_BITS-1. Unsigned only.
- Beat acceptance: a beat is accepted when s_valid && s_ready. It writes q into fill-buffer slot idx (idx = beat counter), then the counter increments.
- States:
  - FILL: s_ready=1.
  - WAIT: s_ready=0. A complete frame is held in the fill buffer and the output slot is occupied.
  - DISCARD: s_ready=1. Beats are dropped until s_last.
- Frame completion occurs on the accepted beat where idx==NUM_FEATURES-1, or on an accepted beat with s_last.
- Early s_last (idx < NUM_FEATURES-1):
  - Slots above idx are forced to 0 in the frame.
  - err_short pulses in the cycle after that beat.
  - The frame is still delivered.
- Beat idx==NUM_FEATURES-1 accepted without s_last:
  - The frame completes normally.
  - err_long pulses the next cycle.
  - Next state is DISCARD (or WAIT, then DISCARD, if the output slot is busy).
- DISCARD: beats are accepted and ignored. The beat carrying s_last returns the state to FILL with counter 0. No frame is produced from discarded beats.
- Handoff: the output slot is free when !m_valid || m_ready.
  - If the slot is free at the completion edge, m_data loads the assembled frame (including the completing beat) and m_valid=1 the next cycle. Latency is 1 cycle from the final beat.
  - If the slot is busy, go to WAIT. Transfer on the first edge where m_ready=1. Leave WAIT the cycle after.
- Output rules:
  - m_data and m_valid are registered. m_data is stable while m_valid && !m_ready.
  - m_valid drops after m_ready unless a new frame loads the same edge (back-to-back with no bubble is allowed).
  - frame_count increments on each m_valid && m_ready.
- Simultaneous events: a completion beat and m_ready in the same cycle is treated as slot free.
- Fill buffer reuse: the fill buffer clears to 0 at each handoff, so early-terminated frames never leak stale codes.
- Reset mid-frame or mid-WAIT: the partial frame is dropped, the output slot is cleared, and no error pulse is produced.
- Throughput: 1 sample/cycle sustained while m_ready is held high.

Decomposition:
- Shared package hgcal_pkg holds:
  - Q_BITS and the IN_WIDTH default.
  - The state enum {FILL, WAIT, DISCARD}.
  - The beat-counter width function clog2(NUM_FEATURES).
- One sub-module, hgcal_quantiser (purely combinational shift-and-saturate). It is reused by other input stages.

Test Plan:
All scenarios use NUM_FEATURES=4, IN_WIDTH=8, Q_BITS=2, SHIFT=2.
1. Normal frame: beats 0x00,0x05,0x0B,0xFF with s_last on the 4th, m_ready=1 -> m_valid the cycle after beat 4, m_data=8'hE4, frame_count=1, no errors.
2. Back-pressure: two frames back-to-back with m_ready=0 -> frame 1 held stable, s_ready=0 after frame 2's last beat. Raise m_ready for one cycle -> frame 2 appears the next cycle and s_ready returns to 1.
3. Short frame: beats 0x0C,0x08 with s_last on the 2nd -> err_short pulse, m_data=8'h0B (upper slots 0).
4. Long frame: 6 beats all 0xFF, s_last on the 6th -> m_data=8'hFF after beat 4, err_long pulse, beats 5-6 dropped. The next frame of 4×0x04 yields m_data=8'h55.
5. Reset mid-frame: assert rst after 2 beats -> m_valid=0, frame_count=0. A following full frame is packed correctly from slot 0.
6. Saturation and bubbles: s_valid toggling 1/0 with values 0x03,0x04,0x0F,0x10 -> m_data=8'hF4 (0,1,3,3).
